// File: rtl/wb_pkg.sv
// Shared writeback-select definitions for the MEM/WB stage and the hazard unit.
// Select codes match the input order of the writeback 4:1 data mux.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    typedef logic [1:0] wb_sel_t;

    localparam wb_sel_t WB_SEL_MEM   = 2'b00;
    localparam wb_sel_t WB_SEL_JUMP  = 2'b01;
    localparam wb_sel_t WB_SEL_AUIPC = 2'b10;
    localparam wb_sel_t WB_SEL_LUI   = 2'b11;

endpackage

// File: rtl/wb_class_encoder.sv
// Instruction-class flags to writeback select code (lui > auipc > jump > load).
// multi_o flags an illegal combination of two or more class flags.
module wb_class_encoder
    import wb_pkg::*;
(
    input  logic       is_load_i,
    input  logic       is_jump_i,
    input  logic       is_auipc_i,
    input  logic       is_lui_i,
    output logic [1:0] sel_o,
    output logic       multi_o
);

    logic [2:0] n_flags;

    always_comb begin
        sel_o = WB_SEL_MEM;
        if (is_lui_i) begin
            sel_o = WB_SEL_LUI;
        end else if (is_auipc_i) begin
            sel_o = WB_SEL_AUIPC;
        end else if (is_jump_i) begin
            sel_o = WB_SEL_JUMP;
        end
    end

    always_comb begin
        n_flags = 3'(is_load_i) + 3'(is_jump_i)
                + 3'(is_auipc_i) + 3'(is_lui_i);
        multi_o = (n_flags > 3'd1);
    end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB stage register with writeback-source select and resolved data.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic              is_load_i,
    input  logic              is_jump_i,
    input  logic              is_auipc_i,
    input  logic              is_lui_i,
    input  logic              reg_write_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] auipc_res_i,
    input  logic [DATA_W-1:0] imm_u_i,
    output logic [1:0]        wb_sel_o,
    output logic [DATA_W-1:0] wb_a_o,
    output logic [DATA_W-1:0] wb_b_o,
    output logic [DATA_W-1:0] wb_c_o,
    output logic [DATA_W-1:0] wb_d_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic              wb_reg_write_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic              wb_err_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       wb_retired_o
`endif
);

    logic [1:0]        sel_in;
    logic              multi_in;
    logic [DATA_W-1:0] data_in;
    logic              capture;

    logic              valid_q, valid_d;
    logic              rw_q, rw_d;
    logic [1:0]        sel_q, sel_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    wb_class_encoder u_enc (
        .is_load_i  (is_load_i),
        .is_jump_i  (is_jump_i),
        .is_auipc_i (is_auipc_i),
        .is_lui_i   (is_lui_i),
        .sel_o      (sel_in),
        .multi_o    (multi_in)
    );

    // Resolve from the raw inputs so the output is a plain flop.
    always_comb begin
        unique case (sel_in)
            WB_SEL_JUMP:  data_in = pc_plus4_i;
            WB_SEL_AUIPC: data_in = auipc_res_i;
            WB_SEL_LUI:   data_in = imm_u_i;
            default:      data_in = mem_data_i;
        endcase
    end

    assign capture = !flush_i && !stall_i;

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        data_d  = data_q;
        err_d   = err_q;
        if (flush_i) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            sel_d   = WB_SEL_MEM;
            rd_d    = '0;
            a_d     = '0;
            b_d     = '0;
            c_d     = '0;
            d_d     = '0;
            data_d  = '0;
        end else if (!stall_i) begin
            valid_d = in_valid_i;
            rw_d    = in_valid_i && reg_write_i && (rd_i != '0);
            sel_d   = sel_in;
            rd_d    = rd_i;
            a_d     = mem_data_i;
            b_d     = pc_plus4_i;
            c_d     = auipc_res_i;
            d_d     = imm_u_i;
            data_d  = data_in;
            err_d   = err_q || (in_valid_i && multi_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            sel_q   <= WB_SEL_MEM;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign wb_valid_o     = valid_q;
    assign wb_reg_write_o = rw_q;
    assign wb_sel_o       = sel_q;
    assign wb_rd_o        = rd_q;
    assign wb_a_o         = a_q;
    assign wb_b_o         = b_q;
    assign wb_c_o         = c_q;
    assign wb_d_o         = d_q;
    assign wb_data_o      = data_q;
    assign wb_err_o       = err_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (capture && in_valid_i) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign wb_retired_o = retired_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: a behavioural model queues the expected
// outputs per clock, a monitor compares them against the DUT on the falling edge.
module tb_wb_select_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, in_valid_i;
    logic        is_load_i, is_jump_i, is_auipc_i, is_lui_i;
    logic        reg_write_i;
    logic [4:0]  rd_i;
    logic [31:0] mem_data_i, pc_plus4_i, auipc_res_i, imm_u_i;
    logic [1:0]  wb_sel_o;
    logic [31:0] wb_a_o, wb_b_o, wb_c_o, wb_d_o, wb_data_o;
    logic        wb_valid_o, wb_reg_write_o, wb_err_o;
    logic [4:0]  wb_rd_o;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_retired_o;
`endif

    always #5 clk = ~clk;

    wb_select_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .is_load_i      (is_load_i),
        .is_jump_i      (is_jump_i),
        .is_auipc_i     (is_auipc_i),
        .is_lui_i       (is_lui_i),
        .reg_write_i    (reg_write_i),
        .rd_i           (rd_i),
        .mem_data_i     (mem_data_i),
        .pc_plus4_i     (pc_plus4_i),
        .auipc_res_i    (auipc_res_i),
        .imm_u_i        (imm_u_i),
        .wb_sel_o       (wb_sel_o),
        .wb_a_o         (wb_a_o),
        .wb_b_o         (wb_b_o),
        .wb_c_o         (wb_c_o),
        .wb_d_o         (wb_d_o),
        .wb_data_o      (wb_data_o),
        .wb_valid_o     (wb_valid_o),
        .wb_reg_write_o (wb_reg_write_o),
        .wb_rd_o        (wb_rd_o),
        .wb_err_o       (wb_err_o)
`ifdef WB_RETIRE_CNT_EN
        ,
        .wb_retired_o   (wb_retired_o)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        err;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] a, b, c, d, data;
        logic [31:0] ret;
    } exp_t;

    exp_t model;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid", 32'(wb_valid_o), 32'(e.valid));
                chk("reg_write", 32'(wb_reg_write_o), 32'(e.rw));
                chk("err", 32'(wb_err_o), 32'(e.err));
                chk("sel", 32'(wb_sel_o), 32'(e.sel));
                chk("rd", 32'(wb_rd_o), 32'(e.rd));
                chk("cand_a", wb_a_o, e.a);
                chk("cand_b", wb_b_o, e.b);
                chk("cand_c", wb_c_o, e.c);
                chk("cand_d", wb_d_o, e.d);
                chk("data", wb_data_o, e.data);
`ifdef WB_RETIRE_CNT_EN
                chk("retired", wb_retired_o, e.ret);
`endif
            end
        end
    end

    // Reference: the highest-priority class flag picks the candidate.
    task automatic update_model();
        logic [31:0] cand [4];
        int          code;
        int          nflags;
        cand[0] = mem_data_i;
        cand[1] = pc_plus4_i;
        cand[2] = auipc_res_i;
        cand[3] = imm_u_i;
        code = 0;
        if (is_jump_i)  code = 1;
        if (is_auipc_i) code = 2;
        if (is_lui_i)   code = 3;
        nflags = int'(is_load_i) + int'(is_jump_i)
               + int'(is_auipc_i) + int'(is_lui_i);
        if (!rst_n) begin
            model = '0;
        end else if (flush_i) begin
            model.valid = 0;
            model.rw    = 0;
            model.sel   = 0;
            model.rd    = 0;
            model.a     = 0;
            model.b     = 0;
            model.c     = 0;
            model.d     = 0;
            model.data  = 0;
        end else if (!stall_i) begin
            model.valid = in_valid_i;
            model.rw    = in_valid_i && reg_write_i && rd_i != 0;
            model.sel   = 2'(code);
            model.rd    = rd_i;
            model.a     = cand[0];
            model.b     = cand[1];
            model.c     = cand[2];
            model.d     = cand[3];
            model.data  = cand[code];
            if (in_valid_i && nflags >= 2) model.err = 1;
            if (in_valid_i) model.ret = model.ret + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        update_model();
        exp_q.push_back(model);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] fl,
                         input logic rw, input logic [4:0] rd);
        in_valid_i  = v;
        is_load_i   = fl[0];
        is_jump_i   = fl[1];
        is_auipc_i  = fl[2];
        is_lui_i    = fl[3];
        reg_write_i = rw;
        rd_i        = rd;
    endtask

    task automatic rand_inputs();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0:       drive($urandom_range(0, 3) != 0, 4'b0000,
                           1'($urandom), 5'($urandom));
            5:       drive($urandom_range(0, 3) != 0, 4'($urandom),
                           1'($urandom), 5'($urandom));
            default: drive($urandom_range(0, 3) != 0, 4'(1 << (k - 1)),
                           1'($urandom), 5'($urandom));
        endcase
        if ($urandom_range(0, 7) == 0) rd_i = 0;
        mem_data_i  = $urandom;
        pc_plus4_i  = $urandom;
        auipc_res_i = $urandom;
        imm_u_i     = $urandom;
    endtask

    initial begin
        model = '0;
        rst_n = 0;
        stall_i = 0;
        flush_i = 0;
        rand_inputs();
        stall_i = 1'($urandom);
        flush_i = 1'($urandom);
        step();
        rand_inputs();
        step();

        rst_n = 1;
        stall_i = 0;
        flush_i = 0;
        mem_data_i  = 32'hDEADBEEF;
        pc_plus4_i  = 32'h104;
        auipc_res_i = 32'h2100;
        imm_u_i     = 32'h12345000;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(1 << i), 1, 5);
            step();
        end

        drive(1, 4'b1000, 1, 0);
        step();

        drive(1, 4'b1000, 1, 7);
        step();
        stall_i = 1;
        drive(1, 4'b0001, 1, 9);
        mem_data_i = 32'hCAFEF00D;
        repeat (3) step();
        stall_i = 0;
        step();

        stall_i = 1;
        flush_i = 1;
        drive(1, 4'b0010, 1, 3);
        step();
        stall_i = 0;
        flush_i = 0;

        drive(1, 4'b1010, 1, 4);
        step();
        drive(1, 4'b0001, 1, 6);
        repeat (3) step();
        rst_n = 0;
        step();
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst_n   = ($urandom_range(0, 49) != 0);
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            step();
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- MEM/WB boundary register and writeback-source encoder for the pipelined RV32I core.
- Classifies each retiring instruction (load/ALU path, JAL/JALR, AUIPC, LUI) into the 2-bit writeback select code consumed by the writeback 4:1 data mux.
- Registers the four candidate values, rd and reg-write enable.
- Also produces the resolved writeback value for the register file and forwarding unit.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- stall_i  in  1  hold the stage register
- flush_i  in  1  squash the incoming instruction
- in_valid_i  in  1  MEM-stage instruction valid
- is_load_i  in  1  class flag: load or ALU result on mem_data_i
- is_jump_i  in  1  class flag: JAL/JALR, writes pc+4
- is_auipc_i  in  1  class flag: AUIPC
- is_lui_i  in  1  class flag: LUI
- reg_write_i  in  1  instruction writes rd
- rd_i  in  REG_AW  destination register
- mem_data_i  in  DATA_W  load data / ALU result
- pc_plus4_i  in  DATA_W  link address
- auipc_res_i  in  DATA_W  pc + imm_u
- imm_u_i  in  DATA_W  U-immediate (LUI value)
- wb_sel_o  out  2  00 mem/ALU, 01 jump, 10 AUIPC, 11 LUI
- wb_a_o, wb_b_o, wb_c_o, wb_d_o  out  DATA_W  registered candidates, in select-code order
- wb_data_o  out  DATA_W  candidate selected by wb_sel_o
- wb_valid_o  out  1  stage holds a live instruction
- wb_reg_write_o  out  1  register-file write enable
- wb_rd_o  out  REG_AW  register-file write address
- wb_err_o  out  1  sticky: more than one class flag seen

Behaviour:
- Reset (rst_n=0 at posedge clk): every output is 0, including wb_err_o.
- Encoding priority: lui > auipc > jump > load. No flag set gives code 00.
- Latency: one cycle, inputs to outputs.
- Update rule, evaluated at each posedge in this order:
  - Reset wins over everything.
  - flush_i=1: load a bubble (valid=0, reg_write=0, sel=00, data and candidates 0, rd=0). Flush wins over stall.
  - stall_i=1: all outputs hold.
  - Otherwise: capture inputs.
- wb_valid_o = in_valid_i.
- wb_reg_write_o = in_valid_i & reg_write_i & (rd_i != 0). A write to x0 is never issued.
- wb_data_o is registered. It is computed from the inputs, never from the registered candidates, so it adds no extra delay.
- When valid=0, wb_data_o and the candidates are still captured; consumers must qualify them with wb_valid_o.
- wb_err_o sets when a valid, non-flushed, non-stalled capture has two or more flags set. It clears only on reset. The stage still uses the priority encoding in that case.
- A stall lasting N cycles holds the outputs for N cycles exactly; the stage never drops or duplicates an instruction.
- Reset asserted mid-stall clears the stage; the held instruction is lost by design.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN
- Defined:
  - Adds output wb_retired_o [31:0].
  - Increments by 1 on every posedge where a valid, non-flushed instruction is captured (stall_i=0).
  - Wraps from 0xFFFFFFFF to 0.
  - Resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - WB_SEL_MEM=2'b00, WB_SEL_JUMP=2'b01, WB_SEL_AUIPC=2'b10, WB_SEL_LUI=2'b11
  - the DATA_W/REG_AW defaults
  - a wb_sel_t 2-bit typedef
- Sub-module: wb_class_encoder, combinational. Flags in; sel code and multi-flag error out. It is reused by the hazard unit.
- The stage register stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, with inputs random -> all outputs 0; wb_err_o=0.
- Classes in sequence, mem=0xDEADBEEF, pc+4=0x104, auipc=0x2100, imm=0x12345000, rd=5, reg_write=1:
  - load -> sel=00, data=0xDEADBEEF
  - jump -> sel=01, data=0x104
  - auipc -> sel=10, data=0x2100
  - lui -> sel=11, data=0x12345000
  - each result appears one cycle after its input.
- rd=0, reg_write=1, LUI -> wb_valid_o=1, wb_reg_write_o=0, data=0x12345000.
- Capture a LUI, then stall 3 cycles while the inputs change to a load -> outputs hold the LUI for 3 cycles; load appears the cycle after stall drops.
- flush_i=1 together with stall_i=1 and a valid jump -> next cycle valid=0, reg_write=0, sel=00, data=0.
- is_jump=1 and is_lui=1 together, valid -> sel=11, wb_err_o=1 and it stays 1 until reset.
  - With WB_RETIRE_CNT_EN defined: counter preloaded via 0xFFFFFFFF captures -> wraps to 0.
